fifo_lanes_tx: RTL
==================

Name: fifo_lanes_tx

Overview:
Four-lane transmit buffer that sits directly upstream of the PHY and drives its in0..in3 / valid_in0..valid_in3 inputs.
Each lane is an independent synchronous FIFO, written by the packet source and drained while the PHY side asserts pop_en.
The block provides per-lane occupancy flags and one aggregate pause signal for source back-pressure.
Single clock domain (clk_32f).

Parameters:
DATA_W, 8, width of each lane byte.
DEPTH, 4, entries per lane FIFO; must be a power of 2.
ADDR_W, 2, log2(DEPTH); pointer width.

Ports:
clk_32f  input  1  sole clock; all state updates on its rising edge.
reset_L  input  1  asynchronous, active-low reset.
data_in0..data_in3  input  DATA_W each  per-lane write data.
push0..push3  input  1 each  per-lane write request.
pop_en  input  1  downstream ready; enables a read on every non-empty lane.
umbral_alto  input  ADDR_W+1  almost-full threshold; legal range 1..DEPTH.
umbral_bajo  input  ADDR_W+1  almost-empty threshold; legal range 0..DEPTH-1.
out0..out3  output  DATA_W each  per-lane read data, registered; feeds PHY in0..in3.
valid_out0..valid_out3  output  1 each  registered; feeds PHY valid_in0..valid_in3.
full0..full3  output  1 each  count == DEPTH.
empty0..empty3  output  1 each  count == 0.
almost_full0..almost_full3  output  1 each  count >= umbral_alto.
almost_empty0..almost_empty3  output  1 each  count <= umbral_bajo.
pause  output  1  OR of almost_full0..3.
overflow_err0..overflow_err3  output  1 each  sticky: set when a write was dropped.

Behaviour:
- Per-lane state: mem[DEPTH], wr_ptr and rd_ptr (ADDR_W bits), count (ADDR_W+1 bits).
- Reset (reset_L=0, asynchronous, effective immediately):
  - pointers, count, out*, valid_out* and overflow_err* go to 0.
  - Flags then read empty=1, full=0, almost_full=0, almost_empty=1, pause=0.
  - mem contents are don't-care.
- Write: on a clock edge with pushK=1 and the lane accepting, mem[wr_ptr] <= data_inK and wr_ptr increments.
  - A lane accepts a write if it is not full, or if it is full and a read occurs on the same edge.
- Read: on a clock edge with pop_en=1 and the lane not empty:
  - outK <= mem[rd_ptr], valid_outK <= 1, rd_ptr increments.
  - Otherwise valid_outK <= 0 and outK holds its previous value.
- Lanes are fully independent. pop_en is shared, and each non-empty lane reads on its own.
- Count update: count +1 on write only, -1 on read only, unchanged when both or neither occur.
- Pointer wrap: pointers wrap modulo DEPTH naturally; there is no extra wrap bit, since count disambiguates full from empty.
- Latency: a byte pushed at edge n is readable at edge n+1 at the earliest, so valid_out rises after edge n+1. There is no write-through bypass.
- Empty lane with simultaneous push and pop: the push is stored, no read occurs, and valid_outK=0 that cycle.
- Full lane with simultaneous push and pop: both happen, count stays DEPTH, no overflow.
- Full lane with push and no read: data is dropped, state is unchanged, and overflow_errK <= 1 until reset.
- Pop on an empty lane: no pointer or count change, valid_outK=0, no error.
- Flags are combinational from the registered count and the threshold inputs. Thresholds must be held static outside reset; changing them mid-run only changes the flags, never the data.
- Reset asserted mid-operation discards all buffered data. The first write after release goes to address 0.

Test Plan:
1. Reset, then one push to lane0 with data_in0=0xBC and pop_en=0 -> empty0=0; then pop_en=1 for 1 cycle -> out0=0xBC, valid_out0=1 for exactly 1 cycle, empty0=1.
2. Push 0x01,0x02,0x03,0x04 into lane2 with umbral_alto=3 -> almost_full2 and pause rise after the 3rd write, full2=1 after the 4th. Then push 0x05 with no pop -> dropped, overflow_err2=1 and stays 1. Then drain -> out2 sequence 0x01..0x04 with no 0x05.
3. Lane1 full, push 0xAA with pop_en=1 on the same edge -> out1=oldest byte, count stays 4, overflow_err1=0. After draining, 0xAA is read last.
4. Lane3 empty, push 0x55 with pop_en=1 on the same edge -> valid_out3=0 that cycle; next cycle out3=0x55, valid_out3=1.
5. Interleaved pushes on lanes 0..3 (0x10/0x20/0x30/0x40 per lane), 6 write-read cycles each with pointers wrapping -> per-lane order preserved, no cross-lane mixing.
6. Assert reset_L=0 asynchronously between clock edges with 3 bytes held -> outputs clear immediately, empty=1; after release, the next push/pop returns only the new byte.

Source files
------------

// File: rtl/fifo_lanes_tx.sv
// Four independent lane FIFOs feeding the PHY inputs, with per-lane occupancy
// flags, sticky overflow indication and an aggregate pause for the source.
module fifo_lanes_tx #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk_32f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic              push0,
  input  logic              push1,
  input  logic              push2,
  input  logic              push3,
  input  logic              pop_en,
  input  logic [ADDR_W:0]   umbral_alto,
  input  logic [ADDR_W:0]   umbral_bajo,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic              valid_out2,
  output logic              valid_out3,
  output logic              full0,
  output logic              full1,
  output logic              full2,
  output logic              full3,
  output logic              empty0,
  output logic              empty1,
  output logic              empty2,
  output logic              empty3,
  output logic              almost_full0,
  output logic              almost_full1,
  output logic              almost_full2,
  output logic              almost_full3,
  output logic              almost_empty0,
  output logic              almost_empty1,
  output logic              almost_empty2,
  output logic              almost_empty3,
  output logic              pause,
  output logic              overflow_err0,
  output logic              overflow_err1,
  output logic              overflow_err2,
  output logic              overflow_err3
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] din  [4];
  logic [DATA_W-1:0] dout [4];
  logic [3:0]        push;
  logic [3:0]        vld;
  logic [3:0]        full_v;
  logic [3:0]        empty_v;
  logic [3:0]        afull_v;
  logic [3:0]        aempty_v;
  logic [3:0]        ovf_v;

  assign din[0] = data_in0;
  assign din[1] = data_in1;
  assign din[2] = data_in2;
  assign din[3] = data_in3;
  assign push   = {push3, push2, push1, push0};

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              rd;
    logic              wr;

    // A full lane still accepts a write when a read frees a slot on the same edge.
    assign rd = pop_en && (count != '0);
    assign wr = push[k] && ((count != FULL_CNT) || rd);

    always_ff @(posedge clk_32f) begin
      if (wr) mem[wr_ptr] <= din[k];
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        dout[k]  <= '0;
        vld[k]   <= 1'b0;
        ovf_v[k] <= 1'b0;
      end else begin
        vld[k] <= rd;
        if (rd) begin
          dout[k] <= mem[rd_ptr];
          rd_ptr  <= rd_ptr + 1'b1;
        end
        if (wr) wr_ptr <= wr_ptr + 1'b1;
        if (push[k] && !wr) ovf_v[k] <= 1'b1;
        unique case ({wr, rd})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    assign full_v[k]   = (count == FULL_CNT);
    assign empty_v[k]  = (count == '0);
    assign afull_v[k]  = (count >= umbral_alto);
    assign aempty_v[k] = (count <= umbral_bajo);
  end

  assign out0 = dout[0];
  assign out1 = dout[1];
  assign out2 = dout[2];
  assign out3 = dout[3];
  assign {valid_out3, valid_out2, valid_out1, valid_out0} = vld;
  assign {full3, full2, full1, full0} = full_v;
  assign {empty3, empty2, empty1, empty0} = empty_v;
  assign {almost_full3, almost_full2, almost_full1, almost_full0} = afull_v;
  assign {almost_empty3, almost_empty2, almost_empty1, almost_empty0} = aempty_v;
  assign {overflow_err3, overflow_err2, overflow_err1, overflow_err0} = ovf_v;
  assign pause = |afull_v;

endmodule
